cnn_layer_accel_row_feeder: RTL and testbench
=============================================

# cnn_layer_accel_row_feeder

Autonomous job and pixel feeder for `cnn_layer_accel_quad`. It accepts one layer command (rows, cols, rows per fetch), runs the quad's job handshake, and answers every `job_fetch_request` by streaming the next block of input rows from an upstream pixel source onto the quad's `pixel_*` port. Channel count, pixel width and dimension widths are parameters; multi-row fetch bursts with a short final fetch are new behaviour. It sits on `clk_if` between the DMA/source and the quad.

## Interface
- `C_NUM_CHANNELS`, 8, pixel lanes per beat
- `C_PIXEL_WIDTH`, 16, bits per lane
- `C_DIM_W`, 10, width of row/col/rows-per-fetch fields
- `clk_if`  in  1  interface clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_num_rows`, `cmd_num_cols`, `cmd_rows_per_fetch`  in  C_DIM_W each  minus-one encoded (9 means 10)
- `src_valid` / `src_ready`  in/out  1  upstream pixel handshake
- `src_data`  in  C_NUM_CHANNELS*C_PIXEL_WIDTH  lane 0 in bits [C_PIXEL_WIDTH-1:0]
- `job_start` out, `job_accept` in, `job_fetch_request` in, `job_fetch_ack` out, `job_fetch_complete` out, `job_complete` in, `job_complete_ack` out  1 each  quad job handshake
- `pixel_valid` out, `pixel_ready` in  1 each;  `pixel_data`  out  C_NUM_CHANNELS*C_PIXEL_WIDTH
- `busy`  out  1  high from command accept until `done`
- `done`  out  1  one-cycle pulse at job end

## Operation
- FSM: IDLE -> START -> WAIT_REQ -> ACK -> STREAM -> FCOMP -> (WAIT_REQ | WAIT_DONE) -> DACK -> IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid&&cmd_ready`, latch the fields and go to START.
- START: hold `job_start`=1 until `job_accept` is sampled high, then go to WAIT_REQ.
- WAIT_REQ: when `job_fetch_request`=1, go to ACK. ACK pulses `job_fetch_ack` for one cycle.
- STREAM: fetch beats = (cols+1) × min(rows_per_fetch+1, rows remaining).
  - `src_ready` is high only while STREAM, source-accepted count < fetch beats, and the skid buffer has room. The feeder never over-reads the source.
  - The fetch ends on the last output handshake (`pixel_valid&&pixel_ready`).
- FCOMP: pulse `job_fetch_complete`. Next state is WAIT_REQ if rows remain, else WAIT_DONE.
- WAIT_DONE: on `job_complete`=1, go to DACK. DACK pulses `job_complete_ack` and `done`.
- Counters are C_DIM_W+1 bits (rows remaining), C_DIM_W bits (column), and 2·C_DIM_W+1 bits (beat).
- Row remainder: 10 rows at 3 rows per fetch gives fetches of 3, 3, 3, 1 rows.
- `cmd_valid` outside IDLE is ignored and `cmd_ready`=0. `job_fetch_request` outside WAIT_REQ is ignored.

## Timing
- Reset values: every output 0 except `cmd_ready`=1 the first cycle after `rst` deasserts. Skid buffer empty, counters zero, FSM in IDLE.
- `rst` mid-operation aborts the job: no `done`, no `job_fetch_complete`, buffered pixels dropped.
- `job_start` rises the cycle after command accept and falls the cycle after `job_accept` is sampled.
- `job_fetch_ack` is high exactly one cycle, the cycle after `job_fetch_request` is sampled.
- `job_fetch_complete` is high the cycle after the last output beat; `pixel_valid`=0 in that cycle.
- Pixel path: registered 2-entry skid buffer.
  - Latency from source accept to `pixel_valid`: 1 cycle.
  - Full throughput of 1 beat/cycle with `pixel_ready` held high.
  - `pixel_data` stays stable while `pixel_valid&&!pixel_ready`.
- `done` and `job_complete_ack` are the same cycle, the cycle after `job_complete` is sampled. `busy` falls with `done`.

## Configuration
- `CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN`:
  - Defined: adds outputs `stat_stall_cycles` (32 b) and `stat_fetches` (16 b).
    - `stat_stall_cycles` counts STREAM cycles with `pixel_valid&&!pixel_ready`.
    - `stat_fetches` counts FCOMP entries.
    - Both counters saturate, clear on command accept and on `rst`, and hold after `done`.
  - Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package `cnn_layer_accel_row_feeder_pkg` holds:
  - the state enum `row_feeder_state_t`;
  - the command struct (rows, cols, rows_per_fetch);
  - localparam `C_BEAT_W` = C_NUM_CHANNELS*C_PIXEL_WIDTH.
- One sub-module, `cnn_layer_accel_skid_buf` (parameter: width), provides the 2-entry registered valid/ready buffer. The FSM and counters are in the top module.

## Test plan
- Cmd 9/9/0 (10×10, 1 row/fetch), 8 channels, `pixel_ready`=1, quad model requests immediately:
  - 10 fetches of 10 beats each;
  - one `job_fetch_ack` per request;
  - `pixel_data` matches source order;
  - `done` once, after `job_complete`.
- Cmd 9/9/2: fetches of 30, 30, 30, 10 beats; exactly 4 `job_fetch_complete` pulses.
- `pixel_ready` random 50%, `src_valid` random 70%: no beat lost or duplicated and `pixel_data` stable under stall. With STATS_EN, `stat_stall_cycles` equals the bench-counted stall cycles and `stat_fetches`=10.
- `job_accept` delayed 7 cycles: `job_start` high exactly 8 cycles. Extra `cmd_valid` while busy is ignored.
- `rst` pulsed mid-fetch 2 of 9/9/0: all outputs 0 next cycle. A new 4/4/0 command then completes with 5 fetches of 5 beats.
- C_NUM_CHANNELS=4, cmd 0/0/0: single fetch of 1 beat of 64 bits; `job_fetch_complete` 1 cycle after the beat.

Source files
------------

// File: rtl/cnn_layer_accel_row_feeder_pkg.sv
// Shared types and constants for the row feeder that supplies jobs and pixel rows to cnn_layer_accel_quad.
package cnn_layer_accel_row_feeder_pkg;

    localparam int C_NUM_CHANNELS_DEF = 8;
    localparam int C_PIXEL_WIDTH_DEF  = 16;
    localparam int C_DIM_W_DEF        = 10;
    localparam int C_BEAT_W           = C_NUM_CHANNELS_DEF * C_PIXEL_WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_REQ  = 3'd2,
        ST_ACK       = 3'd3,
        ST_STREAM    = 3'd4,
        ST_FCOMP     = 3'd5,
        ST_WAIT_DONE = 3'd6,
        ST_DACK      = 3'd7
    } row_feeder_state_t;

    // All fields are minus-one encoded.
    typedef struct packed {
        logic [C_DIM_W_DEF-1:0] rows;
        logic [C_DIM_W_DEF-1:0] cols;
        logic [C_DIM_W_DEF-1:0] rows_per_fetch;
    } row_feeder_cmd_t;

endpackage

// File: rtl/cnn_layer_accel_row_feeder_if.sv
// Command, source, quad-job and pixel signals of the row feeder; slave = feeder side, master = environment side.
interface cnn_layer_accel_row_feeder_if
    import cnn_layer_accel_row_feeder_pkg::*;
#(
    parameter int BEAT_W = C_BEAT_W,
    parameter int DIM_W  = C_DIM_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DIM_W-1:0]  cmd_num_rows;
    logic [DIM_W-1:0]  cmd_num_cols;
    logic [DIM_W-1:0]  cmd_rows_per_fetch;
    logic              src_valid;
    logic              src_ready;
    logic [BEAT_W-1:0] src_data;
    logic              job_start;
    logic              job_accept;
    logic              job_fetch_request;
    logic              job_fetch_ack;
    logic              job_fetch_complete;
    logic              job_complete;
    logic              job_complete_ack;
    logic              pixel_valid;
    logic              pixel_ready;
    logic [BEAT_W-1:0] pixel_data;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_num_rows, cmd_num_cols, cmd_rows_per_fetch,
        input  src_valid, src_data, job_accept, job_fetch_request, job_complete, pixel_ready,
        output cmd_ready, src_ready, job_start, job_fetch_ack, job_fetch_complete,
        output job_complete_ack, pixel_valid, pixel_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_num_rows, cmd_num_cols, cmd_rows_per_fetch,
        output src_valid, src_data, job_accept, job_fetch_request, job_complete, pixel_ready,
        input  cmd_ready, src_ready, job_start, job_fetch_ack, job_fetch_complete,
        input  job_complete_ack, pixel_valid, pixel_data, busy, done
    );

endinterface

// File: rtl/cnn_layer_accel_skid_buf.sv
// Two-entry registered valid/ready buffer: one output register plus one skid register that catches a beat under stall.
module cnn_layer_accel_skid_buf
    import cnn_layer_accel_row_feeder_pkg::*;
#(
    parameter int WIDTH = C_BEAT_W
) (
    input  logic             clk_if,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    // Output register refills from the skid first so beat order is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid;
                out_data_d  = in_valid ? in_data : out_data_q;
            end
        end else begin
            if (in_valid && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/cnn_layer_accel_row_feeder.sv
// Job/pixel feeder for cnn_layer_accel_quad: runs the job handshake and streams row blocks per fetch request.
// Optional statistics outputs are enabled with `define CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN.
module cnn_layer_accel_row_feeder
    import cnn_layer_accel_row_feeder_pkg::*;
#(
    parameter int C_NUM_CHANNELS = C_NUM_CHANNELS_DEF,
    parameter int C_PIXEL_WIDTH  = C_PIXEL_WIDTH_DEF,
    parameter int C_DIM_W        = C_DIM_W_DEF
) (
    input  logic clk_if,
    input  logic rst,
    cnn_layer_accel_row_feeder_if.slave bus
`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [15:0] stat_fetches
`endif
);
    localparam int BEAT_W = C_NUM_CHANNELS * C_PIXEL_WIDTH;
    localparam int CNT_W  = 2 * C_DIM_W + 1;

    row_feeder_state_t  state_q, state_d;
    row_feeder_cmd_t    cmd_q, cmd_d;
    logic [C_DIM_W:0]   rows_rem_q, rows_rem_d;
    logic [C_DIM_W:0]   fetch_left_q, fetch_left_d;
    logic [C_DIM_W-1:0] col_q, col_d;
    logic [CNT_W-1:0]   src_cnt_q, src_cnt_d;
    logic [CNT_W-1:0]   fetch_beats_q, fetch_beats_d;
    logic cmd_ready_q, job_start_q, fetch_ack_q, fetch_comp_q, cplt_ack_q, busy_q, done_q;

    logic              skid_in_ready_s, skid_in_valid_s, src_ready_s, src_hs_s;
    logic              pix_valid_s, pix_hs_s, cmd_accept_s;
    logic [BEAT_W-1:0] pix_data_s;
    logic [C_DIM_W:0]  cols_p1_s, rpf_p1_s, fetch_rows_s;

    assign cmd_accept_s    = (state_q == ST_IDLE) && bus.cmd_valid && cmd_ready_q;
    assign src_ready_s     = (state_q == ST_STREAM) && (src_cnt_q < fetch_beats_q) && skid_in_ready_s;
    assign src_hs_s        = bus.src_valid && src_ready_s;
    assign skid_in_valid_s = src_hs_s;
    assign pix_hs_s        = pix_valid_s && bus.pixel_ready;
    assign cols_p1_s       = {1'b0, cmd_q.cols} + (C_DIM_W+1)'(1);
    assign rpf_p1_s        = {1'b0, cmd_q.rows_per_fetch} + (C_DIM_W+1)'(1);
    assign fetch_rows_s    = (rpf_p1_s < rows_rem_q) ? rpf_p1_s : rows_rem_q;

    cnn_layer_accel_skid_buf #(.WIDTH(BEAT_W)) u_skid (
        .clk_if    (clk_if),
        .rst       (rst),
        .in_valid  (skid_in_valid_s),
        .in_ready  (skid_in_ready_s),
        .in_data   (bus.src_data),
        .out_valid (pix_valid_s),
        .out_ready (bus.pixel_ready),
        .out_data  (pix_data_s)
    );

    // Next-state and counter update for the job sequence.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        rows_rem_d    = rows_rem_q;
        fetch_left_d  = fetch_left_q;
        col_d         = col_q;
        src_cnt_d     = src_cnt_q;
        fetch_beats_d = fetch_beats_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    cmd_d.rows           = bus.cmd_num_rows;
                    cmd_d.cols           = bus.cmd_num_cols;
                    cmd_d.rows_per_fetch = bus.cmd_rows_per_fetch;
                    rows_rem_d           = {1'b0, bus.cmd_num_rows} + (C_DIM_W+1)'(1);
                    state_d              = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START:     state_d = bus.job_accept ? ST_WAIT_REQ : ST_START;
            ST_WAIT_REQ:  state_d = bus.job_fetch_request ? ST_ACK : ST_WAIT_REQ;
            ST_ACK: begin
                fetch_left_d  = fetch_rows_s;
                fetch_beats_d = CNT_W'(cols_p1_s) * CNT_W'(fetch_rows_s);
                src_cnt_d     = '0;
                col_d         = '0;
                state_d       = ST_STREAM;
            end
            ST_STREAM: begin
                src_cnt_d = src_hs_s ? (src_cnt_q + CNT_W'(1)) : src_cnt_q;
                // Output side walks columns; a wrapped column retires one row.
                if (pix_hs_s && (col_q == cmd_q.cols)) begin
                    col_d        = '0;
                    fetch_left_d = fetch_left_q - (C_DIM_W+1)'(1);
                    rows_rem_d   = rows_rem_q - (C_DIM_W+1)'(1);
                    state_d      = (fetch_left_q == (C_DIM_W+1)'(1)) ? ST_FCOMP : ST_STREAM;
                end else if (pix_hs_s) begin
                    col_d = col_q + C_DIM_W'(1);
                end else begin
                    col_d = col_q;
                end
            end
            ST_FCOMP:     state_d = (rows_rem_q != '0) ? ST_WAIT_REQ : ST_WAIT_DONE;
            ST_WAIT_DONE: state_d = bus.job_complete ? ST_DACK : ST_WAIT_DONE;
            ST_DACK:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State, counters and state-decoded handshake outputs.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            rows_rem_q    <= '0;
            fetch_left_q  <= '0;
            col_q         <= '0;
            src_cnt_q     <= '0;
            fetch_beats_q <= '0;
            cmd_ready_q   <= 1'b1;
            job_start_q   <= 1'b0;
            fetch_ack_q   <= 1'b0;
            fetch_comp_q  <= 1'b0;
            cplt_ack_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            rows_rem_q    <= rows_rem_d;
            fetch_left_q  <= fetch_left_d;
            col_q         <= col_d;
            src_cnt_q     <= src_cnt_d;
            fetch_beats_q <= fetch_beats_d;
            cmd_ready_q   <= (state_d == ST_IDLE);
            job_start_q   <= (state_d == ST_START);
            fetch_ack_q   <= (state_d == ST_ACK);
            fetch_comp_q  <= (state_d == ST_FCOMP);
            cplt_ack_q    <= (state_d == ST_DACK);
            busy_q        <= (state_d != ST_IDLE) && (state_d != ST_DACK);
            done_q        <= (state_d == ST_DACK);
        end
    end

`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] fetches_q, fetches_d;

    // Saturating statistics, restarted by each accepted command.
    always_comb begin
        stall_d   = stall_q;
        fetches_d = fetches_q;
        if (cmd_accept_s) begin
            stall_d   = '0;
            fetches_d = '0;
        end else begin
            if ((state_q == ST_STREAM) && pix_valid_s && !bus.pixel_ready && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end else begin
                stall_d = stall_q;
            end
            if ((state_d == ST_FCOMP) && (state_q != ST_FCOMP) && (fetches_q != '1)) begin
                fetches_d = fetches_q + 16'd1;
            end else begin
                fetches_d = fetches_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            stall_q   <= '0;
            fetches_q <= '0;
        end else begin
            stall_q   <= stall_d;
            fetches_q <= fetches_d;
        end
    end

    assign stat_stall_cycles = stall_q;
    assign stat_fetches      = fetches_q;
`endif

    assign bus.cmd_ready          = cmd_ready_q;
    assign bus.src_ready          = src_ready_s;
    assign bus.job_start          = job_start_q;
    assign bus.job_fetch_ack      = fetch_ack_q;
    assign bus.job_fetch_complete = fetch_comp_q;
    assign bus.job_complete_ack   = cplt_ack_q;
    assign bus.pixel_valid        = pix_valid_s;
    assign bus.pixel_data         = pix_data_s;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_row_feeder.sv
// Self-checking bench for cnn_layer_accel_row_feeder: table of layer jobs plus reset-abort and 4-channel corner cases.
module tb_cnn_layer_accel_row_feeder;
    import cnn_layer_accel_row_feeder_pkg::*;

    localparam int NCH = 8;
    localparam int PW  = 16;
    localparam int DW  = 10;
    localparam int BW  = NCH * PW;
    localparam int BW2 = 4 * PW;

    typedef struct {
        int rows; int cols; int rpf;
        int pr_pct; int sv_pct; int acc_dly; int spam;
        int nf; int first; int last;
    } vec_t;

    logic clk_if = 1'b0;
    logic rst;
    always #5 clk_if = ~clk_if;

    cnn_layer_accel_row_feeder_if #(.BEAT_W(BW),  .DIM_W(DW)) bus ();
    cnn_layer_accel_row_feeder_if #(.BEAT_W(BW2), .DIM_W(DW)) bus2 ();

`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
    logic [31:0] stat_stall_cycles, stat_stall_cycles2;
    logic [15:0] stat_fetches, stat_fetches2;
`endif

    cnn_layer_accel_row_feeder #(.C_NUM_CHANNELS(NCH), .C_PIXEL_WIDTH(PW), .C_DIM_W(DW)) dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus)
`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_fetches      (stat_fetches)
`endif
    );

    cnn_layer_accel_row_feeder #(.C_NUM_CHANNELS(4), .C_PIXEL_WIDTH(PW), .C_DIM_W(DW)) dut2 (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus2)
`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles2),
        .stat_fetches      (stat_fetches2)
`endif
    );

    int chk = 0;
    int err = 0;
    int src_idx = 0, exp_idx = 0;
    int cyc, fetch_beats, n_fcomp, n_ack, n_done, n_start_hi, n_stall, busy_viol, spam_left;
    int g_acc_dly, g_pr, g_sv, g_nf, g_first, g_last, g_spam;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data;
    vec_t vecs[4];

    function automatic logic [BW-1:0] pat(input int idx);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k*PW +: PW] = PW'(idx * NCH + k + 1);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock of DUT 1: sample at negedge, then drive source/quad/command models after posedge.
    task automatic step();
        logic s_start, s_ack, s_fcomp, s_cack, s_busy, s_cmd_hs;
        @(negedge clk_if);
        s_start  = bus.job_start;
        s_ack    = bus.job_fetch_ack;
        s_fcomp  = bus.job_fetch_complete;
        s_cack   = bus.job_complete_ack;
        s_busy   = bus.busy;
        s_cmd_hs = bus.cmd_valid && bus.cmd_ready;
        if (bus.src_valid && bus.src_ready) src_idx++;
        if (prev_stall) begin
            check("pix_hold_valid", int'(bus.pixel_valid), 1);
            check_vec("pix_stable", bus.pixel_data, prev_data);
        end
        if (bus.pixel_valid && bus.pixel_ready) begin
            check_vec("pix_data", bus.pixel_data, pat(exp_idx));
            exp_idx++;
            fetch_beats++;
        end
        prev_stall = bus.pixel_valid && !bus.pixel_ready;
        prev_data  = bus.pixel_data;
        if (prev_stall) n_stall++;
        if (s_fcomp) begin
            check("fcomp_pix_valid", int'(bus.pixel_valid), 0);
            check("fetch_beats", fetch_beats, (n_fcomp == g_nf - 1) ? g_last : g_first);
            n_fcomp++;
            fetch_beats = 0;
        end
        if (s_ack) n_ack++;
        if (bus.done) begin
            n_done++;
            check("done_with_cack", int'(bus.job_complete_ack), 1);
            check("busy_at_done", int'(bus.busy), 0);
        end
        if (bus.busy && bus.cmd_ready) busy_viol++;
        if (s_start) n_start_hi++;
        cyc++;
        @(posedge clk_if);
        #1;
        bus.src_valid   = ($urandom_range(99) < g_sv);
        bus.src_data    = pat(src_idx);
        bus.pixel_ready = ($urandom_range(99) < g_pr);
        bus.job_accept  = s_start && (n_start_hi >= g_acc_dly);
        if (bus.job_accept) bus.job_fetch_request = 1'b1;
        if (s_ack) bus.job_fetch_request = 1'b0;
        if (s_fcomp && (n_fcomp < g_nf)) bus.job_fetch_request = 1'b1;
        if (s_fcomp && (n_fcomp >= g_nf)) bus.job_complete = 1'b1;
        if (s_cack) bus.job_complete = 1'b0;
        if ((g_spam != 0) && s_busy && (spam_left > 0)) begin
            bus.cmd_valid          = 1'b1;
            bus.cmd_num_rows       = DW'(3);
            bus.cmd_num_cols       = DW'(3);
            bus.cmd_rows_per_fetch = DW'(3);
            spam_left--;
        end else if (s_cmd_hs || s_busy) begin
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic start_job(input vec_t v);
        g_acc_dly = v.acc_dly; g_pr = v.pr_pct; g_sv = v.sv_pct;
        g_nf = v.nf; g_first = v.first; g_last = v.last; g_spam = v.spam;
        cyc = 0; fetch_beats = 0; n_fcomp = 0; n_ack = 0; n_done = 0;
        n_start_hi = 0; n_stall = 0; busy_viol = 0; spam_left = 20;
        bus.cmd_num_rows       = DW'(v.rows);
        bus.cmd_num_cols       = DW'(v.cols);
        bus.cmd_rows_per_fetch = DW'(v.rpf);
        bus.cmd_valid          = 1'b1;
    endtask

    task automatic run_job(input vec_t v);
        int s0, e0, total;
        s0 = src_idx;
        e0 = exp_idx;
        total = (v.cols + 1) * (v.rows + 1);
        start_job(v);
        while ((n_done == 0) && (cyc < 5000)) step();
        check("job_finished", (n_done > 0) ? 1 : 0, 1);
        repeat (3) step();
        check("fetch_count", n_fcomp, v.nf);
        check("ack_count", n_ack, v.nf);
        check("done_count", n_done, 1);
        check("beats_out", exp_idx - e0, total);
        check("src_accepts", src_idx - s0, total);
        check("start_cycles", n_start_hi, v.acc_dly + 1);
        check("cmd_ready_busy", busy_viol, 0);
`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
        check("stat_stall", int'(stat_stall_cycles), n_stall);
        check("stat_fetches", int'(stat_fetches), v.nf);
`endif
    endtask

    initial begin
        int beat_cyc, fc_cyc, n_beat2, n_src2, n_fc2, n_done2;
        logic acc2;
        logic [BW2-1:0] d2;
        vec_t vr;
        vecs[0] = '{9, 9, 0, 100, 100, 1, 0, 10, 10, 10};
        vecs[1] = '{9, 9, 2, 100, 100, 1, 0,  4, 30, 10};
        vecs[2] = '{9, 9, 0,  50,  70, 1, 0, 10, 10, 10};
        vecs[3] = '{9, 9, 0, 100, 100, 7, 1, 10, 10, 10};
        vr      = '{4, 4, 0, 100, 100, 1, 0,  5,  5,  5};
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_num_rows = '0; bus.cmd_num_cols = '0; bus.cmd_rows_per_fetch = '0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.job_accept = 1'b0; bus.job_fetch_request = 1'b0;
        bus.job_complete = 1'b0; bus.pixel_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_num_rows = '0; bus2.cmd_num_cols = '0; bus2.cmd_rows_per_fetch = '0;
        bus2.src_valid = 1'b0; bus2.src_data = '0; bus2.job_accept = 1'b0; bus2.job_fetch_request = 1'b0;
        bus2.job_complete = 1'b0; bus2.pixel_ready = 1'b0;
        repeat (3) @(posedge clk_if);
        #1 rst = 1'b0;
        @(negedge clk_if);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_job_start", int'(bus.job_start), 0);
        check("rst_pixel_valid", int'(bus.pixel_valid), 0);
        check("rst_src_ready", int'(bus.src_ready), 0);
        check("rst_done", int'(bus.done), 0);
        @(posedge clk_if);
        #1;
        for (int i = 0; i < 4; i++) run_job(vecs[i]);

        // Abort during the second fetch, then a fresh 5x5 job.
        start_job(vecs[0]);
        while (!((n_fcomp == 1) && (fetch_beats >= 3)) && (cyc < 2000)) step();
        check("abort_point_reached", n_fcomp, 1);
        rst = 1'b1;
        bus.src_valid = 1'b0;
        @(posedge clk_if);
        #1 rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.job_accept = 1'b0;
        bus.job_fetch_request = 1'b0; bus.job_complete = 1'b0;
        @(negedge clk_if);
        check("abort_cmd_ready", int'(bus.cmd_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_pixel_valid", int'(bus.pixel_valid), 0);
        check_vec("abort_pixel_data", bus.pixel_data, '0);
        check("abort_fcomp", int'(bus.job_fetch_complete), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_fetch_ack", int'(bus.job_fetch_ack), 0);
        check("abort_src_ready", int'(bus.src_ready), 0);
        exp_idx = src_idx;
        prev_stall = 1'b0;
        @(posedge clk_if);
        #1;
        run_job(vr);

        // Four-channel instance, single 1x1 job.
        beat_cyc = -1; fc_cyc = -1; n_beat2 = 0; n_src2 = 0; n_fc2 = 0; n_done2 = 0; acc2 = 1'b0;
        d2 = 64'hFEDC_BA98_7654_3210;
        bus2.cmd_valid = 1'b1; bus2.src_valid = 1'b1; bus2.src_data = d2; bus2.pixel_ready = 1'b1;
        bus2.job_accept = 1'b1; bus2.job_fetch_request = 1'b1; bus2.job_complete = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_if);
            if (bus2.cmd_valid && bus2.cmd_ready) acc2 = 1'b1;
            if (bus2.src_valid && bus2.src_ready) n_src2++;
            if (bus2.pixel_valid && bus2.pixel_ready) begin
                n_beat2++;
                beat_cyc = c;
                check_vec("q4_pix_data", BW'(bus2.pixel_data), BW'(d2));
            end
            if (bus2.job_fetch_complete) begin
                n_fc2++;
                fc_cyc = c;
            end
            if (bus2.done) n_done2++;
            @(posedge clk_if);
            #1;
            if (acc2) bus2.cmd_valid = 1'b0;
        end
        check("q4_beats", n_beat2, 1);
        check("q4_src_accepts", n_src2, 1);
        check("q4_fetches", n_fc2, 1);
        check("q4_fcomp_latency", fc_cyc - beat_cyc, 1);
        check("q4_done", n_done2, 1);
`ifdef CNN_LAYER_ACCEL_ROW_FEEDER_STATS_EN
        check("q4_stat_fetches", int'(stat_fetches2), 1);
`endif
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
